// File: rtl/decode_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common (package)
// Description : Shared types for the decode queue: raw instruction word,
//               decoded control word, ALU/branch op encoding, RV32 opcode
//               constants and the instruction encoding format enum.
//               The eight RV32M ALU ops are always declared. Whether they
//               are decoded depends on the RV32M_EN macro in instr_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package common;

  localparam int ILEN = 32;

  typedef logic [ILEN-1:0] instruction_type;

  // ALU_ADD must stay at zero so that a cleared control word reads as ADD.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_LUI,
    B_BNE,
    B_BLT,
    B_BGE,
    B_LTU,
    B_GEU,
    ALU_MUL,
    ALU_MULH,
    ALU_MULHSU,
    ALU_MULHU,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    is_branch;
  } control_type;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [2:0] {
    ENC_R = 3'd0,
    ENC_I,
    ENC_S,
    ENC_B,
    ENC_U,
    ENC_J
  } encoding_e;

  // Instruction format implied by the opcode; unknown opcodes report ENC_R.
  function automatic encoding_e opcode_encoding(input logic [6:0] opc);
    encoding_e enc;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: enc = ENC_I;
      OPC_STORE:                      enc = ENC_S;
      OPC_BRANCH:                     enc = ENC_B;
      OPC_LUI, OPC_AUIPC:             enc = ENC_U;
      OPC_JAL:                        enc = ENC_J;
      default:                        enc = ENC_R;
    endcase
    return enc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_queue_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Purely combinational RV32I decode table. Produces the
//               control word plus an illegal flag. Illegal encodings force
//               the control word to all zeros.
//               Macro RV32M_EN: when defined, OP with funct7=0000001 decodes
//               to the M-extension ops; otherwise that encoding is illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
  import common::*;
(
  input  instruction_type instr_i,
  output control_type     control_o,
  output logic            illegal_o
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  control_type w_ctrl;
  logic        w_illegal;
  logic        w_unused_fields;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];
  assign w_funct7 = instr_i[31:25];

  // Register and immediate fields pass through the queue untouched.
  assign w_unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  // Decode table: derive control fields and legality from opcode/funct.
  always_comb begin
    w_ctrl    = '0;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_ctrl.reg_write = 1'b1;
        if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            3'b000:  w_ctrl.alu_op = ALU_ADD;
            3'b001:  w_ctrl.alu_op = ALU_SLL;
            3'b010:  w_ctrl.alu_op = ALU_SLT;
            3'b011:  w_ctrl.alu_op = ALU_SLTU;
            3'b100:  w_ctrl.alu_op = ALU_XOR;
            3'b101:  w_ctrl.alu_op = ALU_SRL;
            3'b110:  w_ctrl.alu_op = ALU_OR;
            default: w_ctrl.alu_op = ALU_AND;
          endcase
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
          w_ctrl.alu_op = ALU_SUB;
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
          w_ctrl.alu_op = ALU_SRA;
`ifdef RV32M_EN
        end else if (w_funct7 == F7_MULDIV) begin
          // M ops are declared contiguously in funct3 order.
          w_ctrl.alu_op = alu_op_e'(5'(ALU_MUL) + {2'b00, w_funct3});
`endif
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        case (w_funct3)
          3'b000: w_ctrl.alu_op = ALU_ADD;
          3'b001: begin
            w_ctrl.alu_op = ALU_SLL;
            w_illegal     = (w_funct7 != F7_BASE);
          end
          3'b010: w_ctrl.alu_op = ALU_SLT;
          3'b011: w_ctrl.alu_op = ALU_SLTU;
          3'b100: w_ctrl.alu_op = ALU_XOR;
          3'b101: begin
            w_ctrl.alu_op = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            w_illegal     = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
          end
          3'b110:  w_ctrl.alu_op = ALU_OR;
          default: w_ctrl.alu_op = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.alu_op     = ALU_ADD;
        w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                    (w_funct3 == 3'b111);
      end
      OPC_STORE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALU_ADD;
        w_illegal        = (w_funct3 > 3'b010);
      end
      OPC_BRANCH: begin
        w_ctrl.is_branch = 1'b1;
        case (w_funct3)
          3'b000:  w_ctrl.alu_op = ALU_SUB;
          3'b001:  w_ctrl.alu_op = B_BNE;
          3'b100:  w_ctrl.alu_op = B_BLT;
          3'b101:  w_ctrl.alu_op = B_BGE;
          3'b110:  w_ctrl.alu_op = B_LTU;
          3'b111:  w_ctrl.alu_op = B_GEU;
          default: w_illegal     = 1'b1;
        endcase
      end
      OPC_JAL: begin
        w_ctrl.is_branch = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALU_ADD;
      end
      OPC_JALR: begin
        w_ctrl.is_branch = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALU_ADD;
        w_illegal        = (w_funct3 != 3'b000);
      end
      OPC_LUI: begin
        w_ctrl.alu_op  = ALU_LUI;
        w_ctrl.alu_src = 1'b1;
      end
      OPC_AUIPC: begin
        w_ctrl.alu_op = ALU_ADD;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign control_o = w_illegal ? '0 : w_ctrl;
  assign illegal_o = w_illegal;

endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_queue
// Description : Circular FIFO of decoded instructions between fetch and
//               issue. Instructions are decoded as they are enqueued; the
//               oldest entry is presented from storage registers. No
//               input-to-output bypass, and in_ready depends only on the
//               stored count. flush clears the queue with top priority.
//               Macro RV32M_EN (consumed by instr_decoder) enables RV32M.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_queue
  import common::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  instruction_type         in_instr,
  input  logic [PC_WIDTH-1:0]     in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output control_type             out_control,
  output instruction_type         out_instr,
  output logic [PC_WIDTH-1:0]     out_pc,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    control_type           control;
    logic                  illegal;
    instruction_type       instr;
    logic [PC_WIDTH-1:0]   pc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  control_type     w_dec_ctrl;
  logic            w_dec_illegal;
  entry_t          w_new_entry;
  entry_t          w_head;
  logic            w_enq;
  logic            w_deq;

  instr_decoder u_decoder (
    .instr_i   (in_instr),
    .control_o (w_dec_ctrl),
    .illegal_o (w_dec_illegal)
  );

  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign w_enq     = in_valid && in_ready;
  assign w_deq     = out_valid && out_ready;

  // Assemble the entry written at the tail.
  always_comb begin
    w_new_entry         = '0;
    w_new_entry.control = w_dec_ctrl;
    w_new_entry.illegal = w_dec_illegal;
    w_new_entry.instr   = in_instr;
    w_new_entry.pc      = in_pc;
  end

  // Next-state pointers and count; pointers wrap because DEPTH is 2**AW.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_enq) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (w_enq && !w_deq) begin
      count_d = count_q + 1'b1;
    end else if (!w_enq && w_deq) begin
      count_d = count_q - 1'b1;
    end
  end

  // Queue bookkeeping; flush discards any same-cycle enqueue/dequeue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are not reset, validity comes from count_q.
  always_ff @(posedge clk) begin
    if (w_enq && !flush) begin
      mem_q[wr_ptr_q] <= w_new_entry;
    end
  end

  assign w_head      = mem_q[rd_ptr_q];
  assign out_control = out_valid ? w_head.control : '0;
  assign out_illegal = out_valid ? w_head.illegal : 1'b0;
  assign out_instr   = out_valid ? w_head.instr   : '0;
  assign out_pc      = out_valid ? w_head.pc      : '0;
  assign occupancy   = count_q;

endmodule
`default_nettype wire
